sequence_player: RTL and testbench
==================================

Name: sequence_player

Overview:
- Plays a stored button-index pattern back to the player on the 8 LEDs.
- Each entry lights one LED for a fixed on-time, then all LEDs go dark for a fixed gap, then the next entry follows.
- This is the output side of the memory game: the capture block records pressed button indices, and this block presents the target sequence before capture begins.
- The difficulty selector supplies the pattern length; the top-level controller issues start and waits for done.

Parameters:
- MAX_LEN, 16, maximum number of pattern entries.
- LEN_W, 5, width of length/index fields; must hold the value MAX_LEN.
- ON_CYCLES, 25000000, clock cycles each LED stays lit (≥1).
- GAP_CYCLES, 12500000, clock cycles of all-dark gap after each entry (≥1).
- CNT_W, 25, width of the on/gap timer; must hold max(ON_CYCLES, GAP_CYCLES).

Ports:
- clk  input  1  system clock; all state changes on the rising edge.
- rst  input  1  asynchronous, active-low reset; 0 forces reset state immediately.
- enable  input  1  1 = run; 0 = freeze timer, index and state; outputs hold.
- start  input  1  request playback; sampled only in IDLE with enable=1.
- pattern  input  3*MAX_LEN  entry i is bits [3i+2:3i], button index 0..7 (index 0 = button 1); latched on accepted start.
- length  input  LEN_W  number of entries to play; latched on accepted start.
- led  output  8  one-hot lit LED (bit n = button n+1), or all zero.
- cur_idx  output  LEN_W  index of the entry currently shown or just shown.
- busy  output  1  high while playback is in progress.
- done  output  1  single-cycle pulse when playback completes.

Behaviour:
- Reset (rst=0, asynchronous) sets state IDLE, led=0, cur_idx=0, busy=0, done=0, timer=0. The latched pattern and length are don't-care.
- Reset is allowed mid-playback: outputs clear immediately and no done pulse is generated.
- All outputs are registered.

State machine: IDLE, SHOW, GAP, FIN.
- IDLE
  - start=1 and enable=1 at edge k: latch pattern, latch len = min(length, MAX_LEN), set cur_idx=0.
  - If len=0: go to FIN. Otherwise go to SHOW with led=onehot(entry 0) and timer=0; busy=1 from edge k.
  - start while not in IDLE is ignored; there is no queuing.
- SHOW
  - led holds onehot(entry cur_idx); timer increments each enabled cycle.
  - When timer=ON_CYCLES-1: go to GAP, led=0, timer=0.
  - Result: the LED is lit for exactly ON_CYCLES enabled cycles.
- GAP
  - led=0 for exactly GAP_CYCLES enabled cycles.
  - At the end of the gap, if cur_idx=len-1: go to FIN, busy=0.
  - Otherwise: cur_idx+1, go to SHOW, led=onehot(next entry).
- FIN
  - done=1 for one cycle, busy=0; return to IDLE.
  - cur_idx holds its last value until the next accepted start.
- Timing: start accepted at edge k → done high during the cycle after edge k+len*(ON_CYCLES+GAP_CYCLES)+1. For len=0, done is high the cycle after edge k+1.
- enable=0 stalls all transitions and counters, including a pending FIN.
  - done stays 0 while stalled and pulses once after enable returns.
  - led, busy and cur_idx hold their values.
- A change to pattern or length during playback has no effect; latched values are used.
- Entries beyond len are never read. led never has more than one bit set.

Test Plan (ON_CYCLES=3, GAP_CYCLES=2):
- Reset, then pulse start with length=3 and entries 5,0,7 → led=0x20 ×3 cycles, 0 ×2, 0x01 ×3, 0 ×2, 0x80 ×3, 0 ×2; cur_idx 0,1,2; busy high 15 cycles; done one pulse at cycle 16.
- length=0, start → no LED activity; done pulses exactly once; busy never rises.
- length=20 (>MAX_LEN) with all entries =2 → exactly 16 flashes of 0x04, then done.
- Mid-playback: drop enable for 4 cycles during SHOW of entry 1 → led and cur_idx frozen; total duration extended by exactly 4 cycles. Second start pulse during busy is ignored; pattern changed during busy does not alter output.
- Assert rst low asynchronously (between clock edges) during GAP → led=0, busy=0, cur_idx=0 immediately; no done. After release, a new start plays from entry 0.
- Back-to-back: start held high continuously → a new playback begins in the cycle after each done pulse, with no overlap.

Source files
------------

// File: rtl/sequence_player.sv
// Memory-game pattern playback: shows each stored button index on the
// LEDs for a fixed on-time followed by an all-dark gap.
module sequence_player #(
  parameter int MAX_LEN    = 16,
  parameter int LEN_W      = 5,
  parameter int ON_CYCLES  = 25000000,
  parameter int GAP_CYCLES = 12500000,
  parameter int CNT_W      = 25
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   enable,
  input  logic                   start,
  input  logic [3*MAX_LEN-1:0]   pattern,
  input  logic [LEN_W-1:0]       length,
  output logic [7:0]             led,
  output logic [LEN_W-1:0]       cur_idx,
  output logic                   busy,
  output logic                   done
);

  typedef enum logic [1:0] {
    IDLE,
    SHOW,
    GAP,
    FIN
  } state_t;

  localparam logic [LEN_W-1:0] MAX_L    = LEN_W'(MAX_LEN);
  localparam logic [CNT_W-1:0] ON_LAST  = CNT_W'(ON_CYCLES - 1);
  localparam logic [CNT_W-1:0] GAP_LAST = CNT_W'(GAP_CYCLES - 1);

  state_t               state_q, state_d;
  logic [CNT_W-1:0]     timer_q, timer_d;
  logic [LEN_W-1:0]     idx_q, idx_d;
  logic [LEN_W-1:0]     len_q, len_d;
  logic [3*MAX_LEN-1:0] pat_q, pat_d;
  logic [7:0]           led_q, led_d;
  logic                 busy_q, busy_d;
  logic                 done_q, done_d;

  function automatic logic [7:0] onehot(
    input logic [3*MAX_LEN-1:0] pat,
    input logic [LEN_W-1:0]     i
  );
    logic [3*MAX_LEN-1:0] sh;
    sh = pat >> (3 * i);
    return 8'b1 << sh[2:0];
  endfunction

  always_comb begin
    state_d = state_q;
    timer_d = timer_q;
    idx_d   = idx_q;
    len_d   = len_q;
    pat_d   = pat_q;
    led_d   = led_q;
    busy_d  = busy_q;
    done_d  = 1'b0;
    if (enable) begin
      unique case (state_q)
        IDLE: begin
          if (start) begin
            pat_d   = pattern;
            len_d   = (length > MAX_L) ? MAX_L : length;
            idx_d   = '0;
            timer_d = '0;
            if (len_d == '0) begin
              state_d = FIN;
              led_d   = '0;
              busy_d  = 1'b0;
            end else begin
              state_d = SHOW;
              led_d   = onehot(pattern, '0);
              busy_d  = 1'b1;
            end
          end
        end
        SHOW: begin
          if (timer_q == ON_LAST) begin
            state_d = GAP;
            led_d   = '0;
            timer_d = '0;
          end else begin
            timer_d = timer_q + CNT_W'(1);
          end
        end
        GAP: begin
          if (timer_q == GAP_LAST) begin
            timer_d = '0;
            if (idx_q == len_q - LEN_W'(1)) begin
              state_d = FIN;
              busy_d  = 1'b0;
            end else begin
              idx_d   = idx_q + LEN_W'(1);
              state_d = SHOW;
              led_d   = onehot(pat_q, idx_d);
            end
          end else begin
            timer_d = timer_q + CNT_W'(1);
          end
        end
        FIN: begin
          done_d  = 1'b1;
          busy_d  = 1'b0;
          state_d = IDLE;
        end
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
      timer_q <= '0;
      idx_q   <= '0;
      len_q   <= '0;
      pat_q   <= '0;
      led_q   <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      timer_q <= timer_d;
      idx_q   <= idx_d;
      len_q   <= len_d;
      pat_q   <= pat_d;
      led_q   <= led_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  assign led     = led_q;
  assign cur_idx = idx_q;
  assign busy    = busy_q;
  assign done    = done_q;

endmodule

// File: tb/tb_sequence_player.sv
// Bench for sequence_player: per-cycle trace from a playback model,
// with stalls, ignored restarts, async reset and back-to-back runs.
module tb_sequence_player;

  localparam int ML = 16;
  localparam int LW = 5;
  localparam int ON = 3;
  localparam int GP = 2;
  localparam int CW = 4;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic          enable = 1'b0;
  logic          start = 1'b0;
  logic [47:0]   pattern = '0;
  logic [LW-1:0] length = '0;
  logic [7:0]    led;
  logic [LW-1:0] cur_idx;
  logic          busy;
  logic          done;

  typedef struct packed {
    logic [7:0]    led;
    logic [LW-1:0] idx;
    logic          busy;
    logic          done;
  } exp_t;

  exp_t tr[$];
  int   total = 0;
  int   bad = 0;

  sequence_player #(
    .MAX_LEN(ML),
    .LEN_W(LW),
    .ON_CYCLES(ON),
    .GAP_CYCLES(GP),
    .CNT_W(CW)
  ) dut (
    .clk(clk),
    .rst(rst),
    .enable(enable),
    .start(start),
    .pattern(pattern),
    .length(length),
    .led(led),
    .cur_idx(cur_idx),
    .busy(busy),
    .done(done)
  );

  always #5 clk = ~clk;

  // Expected outputs after each enabled edge, starting at the accept edge.
  task automatic build(input logic [47:0] pat, input int len_in);
    int   n;
    int   ent;
    exp_t x;
    n = (len_in > ML) ? ML : len_in;
    tr.delete();
    for (int e = 0; e < n; e++) begin
      ent = int'(pat[3*e +: 3]);
      for (int t = 0; t < ON; t++) begin
        x = '{led: 8'(1) << ent, idx: LW'(e), busy: 1'b1, done: 1'b0};
        tr.push_back(x);
      end
      for (int t = 0; t < GP; t++) begin
        x = '{led: 8'h00, idx: LW'(e), busy: 1'b1, done: 1'b0};
        tr.push_back(x);
      end
    end
    x = '{led: 8'h00, idx: LW'((n == 0) ? 0 : n - 1), busy: 1'b0, done: 1'b0};
    tr.push_back(x);
    x.done = 1'b1;
    tr.push_back(x);
  endtask

  // Call at a negedge; returns at the negedge after the done cycle.
  task automatic play(input logic [47:0] pat, input int len_in,
                      input int st_at, input int st_n,
                      input bit disturb, input bit keep,
                      input string nm);
    exp_t e;
    int   p;
    bit   en_now;
    build(pat, len_in);
    pattern = pat;
    length  = LW'(len_in);
    start   = 1'b1;
    enable  = 1'b1;
    p = -1;
    e = '0;
    for (int c = 0; p < tr.size() - 1 && c < 400; c++) begin
      en_now = enable;
      @(negedge clk);
      if (en_now) begin
        p++;
        e = tr[p];
      end else begin
        e.done = 1'b0;
      end
      total++;
      if ({led, cur_idx, busy, done} !== e) begin
        bad++;
        $display("FAIL %s cyc=%0d got led=%h idx=%0d busy=%b done=%b exp led=%h idx=%0d busy=%b done=%b",
                 nm, c, led, cur_idx, busy, done, e.led, e.idx, e.busy, e.done);
      end
      start = keep;
      if (disturb && c == 3) begin
        pattern = ~pat;
        length  = LW'($urandom_range(1, 31));
        start   = 1'b1;
      end
      enable = !((c + 1) >= st_at && (c + 1) < st_at + st_n);
    end
    if (p < tr.size() - 1) begin
      total++;
      bad++;
      $display("FAIL %s timeout got steps=%0d exp steps=%0d", nm, p + 1, tr.size());
    end
  endtask

  task automatic test_reset();
    #1;
    total++;
    if ({led, cur_idx, busy, done} !== '0) begin
      bad++;
      $display("FAIL reset got led=%h idx=%0d busy=%b done=%b exp all zero",
               led, cur_idx, busy, done);
    end
    @(negedge clk);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_basic();
    play(48'o705, 3, 0, 0, 1'b0, 1'b0, "basic");
  endtask

  task automatic test_zero_len();
    play({$urandom, $urandom}, 0, 0, 0, 1'b0, 1'b0, "zero_len");
  endtask

  task automatic test_over_len();
    play(48'o2222222222222222, 20, 0, 0, 1'b0, 1'b0, "over_len");
  endtask

  task automatic test_stall_disturb();
    play(48'o705, 3, 6, 4, 1'b1, 1'b0, "stall");
    play({$urandom, $urandom}, 4, 3, 2, 1'b1, 1'b0, "stall2");
  endtask

  task automatic test_async_reset();
    logic [47:0] pat;
    pat = {$urandom, $urandom};
    pattern = pat;
    length  = 5'd3;
    start   = 1'b1;
    enable  = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (8) @(negedge clk);
    total++;
    if (led !== 8'h00 || cur_idx !== 5'd1 || busy !== 1'b1) begin
      bad++;
      $display("FAIL pre_reset got led=%h idx=%0d busy=%b exp led=00 idx=1 busy=1",
               led, cur_idx, busy);
    end
    #2;
    rst = 1'b0;
    #1;
    total++;
    if ({led, cur_idx, busy, done} !== '0) begin
      bad++;
      $display("FAIL async_reset got led=%h idx=%0d busy=%b done=%b exp all zero",
               led, cur_idx, busy, done);
    end
    @(negedge clk);
    total++;
    if (done !== 1'b0 || busy !== 1'b0) begin
      bad++;
      $display("FAIL reset_hold got done=%b busy=%b exp 0 0", done, busy);
    end
    rst = 1'b1;
    @(negedge clk);
    play({$urandom, $urandom}, 2, 0, 0, 1'b0, 1'b0, "after_reset");
  endtask

  task automatic test_back_to_back();
    play({$urandom, $urandom}, 2, 0, 0, 1'b0, 1'b1, "b2b_a");
    play({$urandom, $urandom}, 1, 0, 0, 1'b0, 1'b1, "b2b_b");
    play({$urandom, $urandom}, 0, 0, 0, 1'b0, 1'b1, "b2b_c");
    play({$urandom, $urandom}, 3, 0, 0, 1'b0, 1'b0, "b2b_d");
  endtask

  task automatic test_random();
    int n;
    for (int i = 0; i < 8; i++) begin
      n = $urandom_range(0, 20);
      play({$urandom, $urandom}, n, $urandom_range(1, 30),
           $urandom_range(0, 3), (n >= 2), 1'b0, "random");
      repeat ($urandom_range(0, 2)) @(negedge clk);
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_zero_len();
    test_over_len();
    test_stall_disturb();
    test_async_reset();
    test_back_to_back();
    test_random();
    @(negedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
